insysbist_ijtag_sequencer: RTL

In-system IJTAG host that sequences a single spare SIB and the segment behind it from a simple request/response interface. Given one request, the block:
- opens the SIB if it is closed,
- performs one capture/shift/update pass over the SIB plus its SEG_LEN-bit segment,
- optionally closes the SIB in the same pass,
- returns the captured segment data.

It sits between the in-system BIST controller (same `ijtag_tck` domain) and the `ijtag_*` port of the spare SIB.

---
 rtl/insysbist_ijtag_seq_pkg.sv | 34 +++
 rtl/insysbist_ijtag_seq_shreg.sv | 63 ++++++
 rtl/insysbist_ijtag_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/insysbist_ijtag_seq_pkg.sv
// insysbist_ijtag_seq_pkg: shared state encodings and helper for the
// in-system IJTAG SIB sequencer.
package insysbist_ijtag_seq_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_OPEN_CAP  = 4'd1;
    localparam logic [3:0] ST_OPEN_SH   = 4'd2;
    localparam logic [3:0] ST_OPEN_UPD  = 4'd3;
    localparam logic [3:0] ST_OPEN_WAIT = 4'd4;
    localparam logic [3:0] ST_ACC_CAP   = 4'd5;
    localparam logic [3:0] ST_ACC_SH    = 4'd6;
    localparam logic [3:0] ST_ACC_UPD   = 4'd7;
    localparam logic [3:0] ST_ACC_WAIT  = 4'd8;
    localparam logic [3:0] ST_RSP       = 4'd9;

    typedef enum logic [3:0] {
        S_IDLE      = ST_IDLE,
        S_OPEN_CAP  = ST_OPEN_CAP,
        S_OPEN_SH   = ST_OPEN_SH,
        S_OPEN_UPD  = ST_OPEN_UPD,
        S_OPEN_WAIT = ST_OPEN_WAIT,
        S_ACC_CAP   = ST_ACC_CAP,
        S_ACC_SH    = ST_ACC_SH,
        S_ACC_UPD   = ST_ACC_UPD,
        S_ACC_WAIT  = ST_ACC_WAIT,
        S_RSP       = ST_RSP
    } state_t;

    // Bit counter must hold 0..seg_len inclusive.
    function automatic int cnt_width(input int seg_len);
        return $clog2(seg_len + 1);
    endfunction

endpackage

// File: rtl/insysbist_ijtag_seq_shreg.sv
// insysbist_ijtag_seq_shreg: write-data latch + si select, ACC_SH bit
// counter (falling tck) and rising-tck so capture register.
// Ports: ijtag_tck, ijtag_reset (async, active-low), load/wdata (latch
//   request data), cnt_inc (advance counter, else clear), cap_en (shift
//   so into capture), so, cnt, si_bit (wdata[cnt]), rdata (captured).
module insysbist_ijtag_seq_shreg
    import insysbist_ijtag_seq_pkg::*;
#(
    parameter int SEG_LEN = 16,
    parameter int CW      = cnt_width(SEG_LEN)
) (
    input  logic               ijtag_tck,
    input  logic               ijtag_reset,
    input  logic               load,
    input  logic [SEG_LEN-1:0] wdata,
    input  logic               cnt_inc,
    input  logic               cap_en,
    input  logic               so,
    output logic [CW-1:0]      cnt,
    output logic               si_bit,
    output logic [SEG_LEN-1:0] rdata
);

    logic [SEG_LEN-1:0] wdata_q;
    logic [SEG_LEN-1:0] cap_q;
    logic [SEG_LEN-1:0] cap_nx;

    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            wdata_q <= '0;
            cnt     <= '0;
        end else begin
            if (load)
                wdata_q <= wdata;
            cnt <= cnt_inc ? cnt + CW'(1) : '0;
        end
    end

    // Bit driven during the next shift cycle: count k+1 carries wdata[k].
    always_comb begin
        si_bit = 1'b0;
        for (int i = 0; i < SEG_LEN; i++)
            if (cnt == CW'(i))
                si_bit = wdata_q[i];
    end

    // LSB-first: the first segment bit out ends up in rdata[0].
    if (SEG_LEN == 1) begin : g_one
        assign cap_nx = so;
    end else begin : g_many
        assign cap_nx = {so, cap_q[SEG_LEN-1:1]};
    end

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset)
            cap_q <= '0;
        else if (cap_en)
            cap_q <= cap_nx;
    end

    assign rdata = cap_q;

endmodule

// File: rtl/insysbist_ijtag_sequencer.sv
// insysbist_ijtag_sequencer: opens a spare SIB if needed, runs one
// capture/shift/update pass over SIB+segment, optionally closes it.
// Ports: ijtag_tck/ijtag_reset, req_* (request), rsp_* (response),
//   sib_open, ijtag_sel/ce/se/ue/si (to SIB), ijtag_so (from SIB).
// Optional macro INSYS_SEQ_SO_CHECK_EN: check SIB capture bits -> rsp_err.
module insysbist_ijtag_sequencer
    import insysbist_ijtag_seq_pkg::*;
#(
    parameter int SEG_LEN = 16
) (
    input  logic               ijtag_tck,
    input  logic               ijtag_reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [SEG_LEN-1:0] req_wdata,
    input  logic               req_close,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [SEG_LEN-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic               sib_open,
    output logic               ijtag_sel,
    output logic               ijtag_ce,
    output logic               ijtag_se,
    output logic               ijtag_ue,
    output logic               ijtag_si,
    input  logic               ijtag_so
);

    localparam int CW = cnt_width(SEG_LEN);

    state_t          state_q, state_d;
    logic            close_q;
    logic            accept;
    logic            last;
    logic            cnt_inc;
    logic            cap_en;
    logic            si_bit;
    logic [CW-1:0]   cnt;
    logic            sel_d, ce_d, se_d, ue_d, si_d, rsp_valid_d;

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_ready & req_valid;
    assign last      = (cnt == CW'(SEG_LEN));
    assign cnt_inc   = (state_q == S_ACC_SH) & ~last;
    assign cap_en    = (state_q == S_ACC_SH) & (cnt != '0);

    insysbist_ijtag_seq_shreg #(
        .SEG_LEN (SEG_LEN),
        .CW      (CW)
    ) u_shreg (
        .ijtag_tck   (ijtag_tck),
        .ijtag_reset (ijtag_reset),
        .load        (accept),
        .wdata       (req_wdata),
        .cnt_inc     (cnt_inc),
        .cap_en      (cap_en),
        .so          (ijtag_so),
        .cnt         (cnt),
        .si_bit      (si_bit),
        .rdata       (rsp_rdata)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (accept)
                             state_d = sib_open ? S_ACC_CAP : S_OPEN_CAP;
            S_OPEN_CAP:  state_d = S_OPEN_SH;
            S_OPEN_SH:   state_d = S_OPEN_UPD;
            S_OPEN_UPD:  state_d = S_OPEN_WAIT;
            S_OPEN_WAIT: state_d = S_ACC_CAP;
            S_ACC_CAP:   state_d = S_ACC_SH;
            S_ACC_SH:    if (last) state_d = S_ACC_UPD;
            S_ACC_UPD:   state_d = S_ACC_WAIT;
            S_ACC_WAIT:  state_d = S_RSP;
            S_RSP:       if (rsp_ready) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they
    // are stable across the SIB's rising edge.
    always_comb begin
        sel_d       = 1'b0;
        ce_d        = 1'b0;
        se_d        = 1'b0;
        ue_d        = 1'b0;
        si_d        = 1'b0;
        rsp_valid_d = 1'b0;
        unique case (state_d)
            S_OPEN_CAP, S_ACC_CAP: begin
                sel_d = 1'b1;
                ce_d  = 1'b1;
            end
            S_OPEN_SH: begin
                sel_d = 1'b1;
                se_d  = 1'b1;
                si_d  = 1'b1;
            end
            S_ACC_SH: begin
                sel_d = 1'b1;
                se_d  = 1'b1;
                // Count 0 is the SIB bit; later counts carry segment data.
                si_d  = (state_q == S_ACC_SH) ? si_bit : ~close_q;
            end
            S_OPEN_UPD, S_ACC_UPD: begin
                sel_d = 1'b1;
                ue_d  = 1'b1;
            end
            S_OPEN_WAIT, S_ACC_WAIT: sel_d = 1'b1;
            S_RSP:       rsp_valid_d = 1'b1;
            default:     sel_d = 1'b0;
        endcase
    end

    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            state_q   <= S_IDLE;
            close_q   <= 1'b0;
            sib_open  <= 1'b0;
            rsp_valid <= 1'b0;
            ijtag_sel <= 1'b0;
            ijtag_ce  <= 1'b0;
            ijtag_se  <= 1'b0;
            ijtag_ue  <= 1'b0;
            ijtag_si  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_valid <= rsp_valid_d;
            ijtag_sel <= sel_d;
            ijtag_ce  <= ce_d;
            ijtag_se  <= se_d;
            ijtag_ue  <= ue_d;
            ijtag_si  <= si_d;
            if (accept)
                close_q <= req_close;
            if (state_q == S_ACC_UPD)
                sib_open <= ~close_q;
        end
    end

`ifdef INSYS_SEQ_SO_CHECK_EN
    logic so_q;

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset)
            so_q <= 1'b0;
        else
            so_q <= ijtag_so;
    end

    // SIB capture bit appears on so in OPEN_SH and in ACC_SH count 0.
    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset)
            rsp_err <= 1'b0;
        else if (accept)
            rsp_err <= 1'b0;
        else if (so_q && ((state_q == S_OPEN_SH) ||
                          ((state_q == S_ACC_SH) && (cnt == '0))))
            rsp_err <= 1'b1;
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule
